// File: rtl/csr_access_arbiter.sv
// Purpose: shares the CSR write port between writeback (priority) and a host port, with bounded host starvation.
// Latency: host_ready is combinational; CSR write 1 cycle after accept; response valid the cycle after that.
// Backpressure: host blocked up to MAX_WAIT cycles by pipeline writes; response held until host_rsp_ready.
// Optional: CSR_ARB_ADDR_FILTER_EN rejects host writes to any address other than tohost (12'h51E).
module csr_access_arbiter #(
    parameter int MAX_WAIT = 8,
    parameter int WAIT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_stall,
    input  logic [11:0] pipe_csr_i,
    input  logic        pipe_csr_we,
    input  logic [31:0] pipe_wb_data,
    output logic        pipe_stall_out,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [11:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic        host_rsp_valid,
    input  logic        host_rsp_ready,
    output logic [31:0] host_rsp_data,
    output logic        host_rsp_err,
    output logic        csr_stall,
    output logic [11:0] csr_i,
    output logic        csr_we,
    output logic [31:0] csr_wdata,
    input  logic [31:0] csrd_tohost
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] HOST_WR  = 2'd1;
    localparam logic [1:0] HOST_RSP = 2'd2;

    localparam logic [11:0]       TOHOST_ADDR = 12'h51E;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT  = WAIT_W'(MAX_WAIT);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [11:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rsp_data_q;
    logic              rsp_first;
    logic              grant;
    logic              accept;
    logic              addr_ok;

    // The host wins whenever the pipeline is not actually writing, or once it has waited long enough.
    assign grant      = host_valid && (!pipe_csr_we || pipe_stall || (wait_cnt == WAIT_LIMIT));
    assign host_ready = (state == IDLE) && grant;
    assign accept     = host_ready;

`ifdef CSR_ARB_ADDR_FILTER_EN
    assign addr_ok = (host_addr == TOHOST_ADDR);
`else
    assign addr_ok = 1'b1;
`endif

    // Next-state: rejected requests skip the write cycle and answer immediately.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = addr_ok ? HOST_WR : HOST_RSP;
            HOST_WR:  state_nxt = HOST_RSP;
            HOST_RSP: if (host_rsp_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Starvation counter: counts blocked cycles of a continuously asserted request, saturating at the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state == IDLE) begin
            if (!host_valid || accept) wait_cnt <= '0;
            else if (wait_cnt != WAIT_LIMIT) wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Capture the host request so the host is free to change its inputs after the handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= host_addr;
            wdata_q <= host_wdata;
        end
    end

    // Response data: the CSR write lands on the edge leaving HOST_WR, so the first response cycle
    // shows csrd_tohost live and that value is frozen at the end of the cycle. Rejected requests
    // snapshot tohost at accept since nothing is written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_data_q <= '0;
            rsp_first  <= 1'b0;
        end else begin
            rsp_first <= (state == HOST_WR);
            if (accept && !addr_ok) rsp_data_q <= csrd_tohost;
            else if ((state == HOST_RSP) && rsp_first) rsp_data_q <= csrd_tohost;
        end
    end

    assign host_rsp_data  = rsp_first ? csrd_tohost : rsp_data_q;
    assign host_rsp_valid = (state == HOST_RSP);

`ifdef CSR_ARB_ADDR_FILTER_EN
    logic rsp_err_q;

    // Error flag is decided at accept and held for the whole response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      rsp_err_q <= 1'b0;
        else if (accept) rsp_err_q <= !addr_ok;
    end

    assign host_rsp_err = rsp_err_q;
`else
    assign host_rsp_err = 1'b0;
`endif

    // CSR port mux: pipeline pass-through except during the single host write cycle, which stalls the pipeline.
    always_comb begin
        csr_stall      = pipe_stall;
        csr_i          = pipe_csr_i;
        csr_we         = pipe_csr_we;
        csr_wdata      = pipe_wb_data;
        pipe_stall_out = 1'b0;
        if (state == HOST_WR) begin
            csr_stall      = 1'b0;
            csr_we         = 1'b1;
            csr_i          = addr_q;
            csr_wdata      = wdata_q;
            pipe_stall_out = 1'b1;
        end
    end

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Directed bench for csr_access_arbiter with a minimal CSR tohost register model.
// Each step drives inputs 1 time unit after the rising edge and samples 1 unit later.
// Covers reset, idle grant, starvation bound, stall grant, response hold, pass-through, address filter.
module tb_csr_access_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_stall;
    logic [11:0] pipe_csr_i;
    logic        pipe_csr_we;
    logic [31:0] pipe_wb_data;
    logic        pipe_stall_out;
    logic        host_valid;
    logic        host_ready;
    logic [11:0] host_addr;
    logic [31:0] host_wdata;
    logic        host_rsp_valid;
    logic        host_rsp_ready;
    logic [31:0] host_rsp_data;
    logic        host_rsp_err;
    logic        csr_stall;
    logic [11:0] csr_i;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic [31:0] tohost = 32'h0;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_tohost;

    csr_access_arbiter #(.MAX_WAIT(8), .WAIT_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .pipe_stall     (pipe_stall),
        .pipe_csr_i     (pipe_csr_i),
        .pipe_csr_we    (pipe_csr_we),
        .pipe_wb_data   (pipe_wb_data),
        .pipe_stall_out (pipe_stall_out),
        .host_valid     (host_valid),
        .host_ready     (host_ready),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_rsp_valid (host_rsp_valid),
        .host_rsp_ready (host_rsp_ready),
        .host_rsp_data  (host_rsp_data),
        .host_rsp_err   (host_rsp_err),
        .csr_stall      (csr_stall),
        .csr_i          (csr_i),
        .csr_we         (csr_we),
        .csr_wdata      (csr_wdata),
        .csrd_tohost    (tohost)
    );

    always #5 clk = ~clk;

    // CSR block model: tohost updates on an unstalled write to 12'h51E.
    always @(posedge clk) begin
        if (csr_we && !csr_stall && (csr_i == 12'h51E)) tohost <= csr_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        pipe_stall     = 1'b0;
        pipe_csr_i     = 12'h0;
        pipe_csr_we    = 1'b0;
        pipe_wb_data   = 32'h0;
        host_valid     = 1'b0;
        host_addr      = 12'h0;
        host_wdata     = 32'h0;
        host_rsp_ready = 1'b0;
        #3 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_rsp_valid", 64'(host_rsp_valid), 64'd0);
        chk("reset_rsp_data",  64'(host_rsp_data),  64'd0);
        chk("reset_rsp_err",   64'(host_rsp_err),   64'd0);
        chk("reset_stall_out", 64'(pipe_stall_out), 64'd0);
        chk("reset_ready",     64'(host_ready),     64'd0);
        tick();
        reset = 1'b1;

        // Idle host write: granted in the same cycle.
        tick();
        host_valid = 1'b1; host_addr = 12'h51E; host_wdata = 32'hDEADBEEF;
        #1;
        chk("idle_ready", 64'(host_ready), 64'd1);
        chk("idle_pass_we", 64'(csr_we), 64'd0);
        tick();
        host_valid = 1'b0;
        #1;
        chk("idle_wr_port", {csr_stall, csr_we, pipe_stall_out, csr_i, csr_wdata}, {1'b0, 1'b1, 1'b1, 12'h51E, 32'hDEADBEEF});
        chk("idle_wr_ready", 64'(host_ready), 64'd0);
        tick();
        host_rsp_ready = 1'b1;
        #1;
        chk("idle_rsp", {host_rsp_valid, pipe_stall_out, host_rsp_err, host_rsp_data}, {1'b1, 1'b0, 1'b0, 32'hDEADBEEF});
        tick();
        host_rsp_ready = 1'b0;
        #1;
        chk("idle_done", {host_rsp_valid, host_rsp_data}, {1'b0, 32'hDEADBEEF});

        // Starvation: a dropped request clears the wait count, then the 9th blocked cycle is granted.
        tick();
        pipe_csr_we = 1'b1; pipe_csr_i = 12'h51E; pipe_wb_data = 32'h11111111;
        host_valid = 1'b1; host_addr = 12'h51E; host_wdata = 32'hA5A5A5A5;
        repeat (5) tick();
        host_valid = 1'b0;
        tick();
        host_valid = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            if (c > 1) tick();
            #1;
            chk($sformatf("starve_ready_c%0d", c), 64'(host_ready), (c == 9) ? 64'd1 : 64'd0);
        end
        tick();
        host_valid = 1'b0;
        #1;
        chk("starve_wr", {pipe_stall_out, csr_we, csr_wdata}, {1'b1, 1'b1, 32'hA5A5A5A5});
        tick();
        host_rsp_ready = 1'b1;
        #1;
        chk("starve_rsp", {pipe_stall_out, host_rsp_valid, host_rsp_data, csr_wdata}, {1'b0, 1'b1, 32'hA5A5A5A5, 32'h11111111});
        tick();
        host_rsp_ready = 1'b0;
        pipe_csr_we = 1'b0;
        #1;
        chk("starve_pipe_landed", 64'(tohost), 64'h11111111);
        chk("starve_rsp_held", {pipe_stall_out, host_rsp_data}, {1'b0, 32'hA5A5A5A5});

        // Pipeline stall: immediate grant even with a pipeline write pending.
        tick();
        pipe_stall = 1'b1; pipe_csr_we = 1'b1; pipe_wb_data = 32'h22222222;
        host_valid = 1'b1; host_wdata = 32'h600DF00D;
        #1;
        chk("stall_ready", {host_ready, csr_stall}, {1'b1, 1'b1});
        tick();
        host_valid = 1'b0;
        #1;
        chk("stall_wr", {csr_stall, csr_we, csr_wdata}, {1'b0, 1'b1, 32'h600DF00D});
        tick();
        // Pipeline now writes tohost under the response; the held response must not follow it.
        pipe_stall = 1'b0; pipe_wb_data = 32'h33333333; host_valid = 1'b1;
        #1;
        chk("stall_rsp", {host_rsp_valid, host_rsp_data}, {1'b1, 32'h600DF00D});
        for (int c = 1; c <= 3; c++) begin
            tick();
            #1;
            chk($sformatf("stall_hold_c%0d", c), {host_rsp_valid, host_ready, host_rsp_data}, {1'b1, 1'b0, 32'h600DF00D});
        end
        host_rsp_ready = 1'b1; host_valid = 1'b0; pipe_csr_we = 1'b0;
        tick();
        host_rsp_ready = 1'b0;
        #1;
        chk("stall_done", {host_rsp_valid, tohost}, {1'b0, 32'h33333333});

        // Pass-through: random pipeline traffic, no host.
        exp_tohost = 32'h33333333;
        for (int n = 0; n < 20; n++) begin
            tick();
            pipe_stall   = ($urandom_range(0, 3) == 0);
            pipe_csr_we  = 1'b1;
            pipe_csr_i   = ($urandom_range(0, 1) == 1) ? 12'h51E : 12'($urandom_range(0, 4095));
            pipe_wb_data = $urandom;
            #1;
            chk($sformatf("pass_n%0d", n), {csr_stall, csr_we, pipe_stall_out, csr_i, csr_wdata},
                {pipe_stall, pipe_csr_we, 1'b0, pipe_csr_i, pipe_wb_data});
            if (!pipe_stall && (pipe_csr_i == 12'h51E)) exp_tohost = pipe_wb_data;
        end
        tick();
        pipe_csr_we = 1'b0; pipe_stall = 1'b0;
        #1;
        chk("pass_tohost", 64'(tohost), 64'(exp_tohost));

        // Host write to a non-tohost address.
        tick();
        host_valid = 1'b1; host_addr = 12'h300; host_wdata = 32'h12345678;
        #1;
        chk("f300_ready", 64'(host_ready), 64'd1);
        tick();
        host_valid = 1'b0;
        #1;
`ifdef CSR_ARB_ADDR_FILTER_EN
        chk("f300_rsp", {csr_we, pipe_stall_out, host_rsp_valid, host_rsp_err, host_rsp_data},
            {1'b0, 1'b0, 1'b1, 1'b1, exp_tohost});
`else
        chk("f300_wr", {csr_we, pipe_stall_out, csr_i, csr_wdata}, {1'b1, 1'b1, 12'h300, 32'h12345678});
        tick();
        #1;
        chk("f300_rsp", {host_rsp_valid, host_rsp_err, host_rsp_data}, {1'b1, 1'b0, exp_tohost});
`endif
        host_rsp_ready = 1'b1;
        tick();
        host_rsp_ready = 1'b0;
        #1;
        chk("f300_done", 64'(host_rsp_valid), 64'd0);

        // Reset in the middle of a response drops it.
        tick();
        host_valid = 1'b1; host_addr = 12'h51E; host_wdata = 32'hCAFEF00D;
        #1;
        chk("mid_ready", 64'(host_ready), 64'd1);
        tick();
        host_valid = 1'b0;
        tick();
        #1;
        chk("mid_in_rsp", {host_rsp_valid, host_rsp_data}, {1'b1, 32'hCAFEF00D});
        reset = 1'b0;
        #1;
        chk("mid_reset", {host_rsp_valid, host_ready, pipe_stall_out, host_rsp_err, host_rsp_data}, {1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
        tick();
        reset = 1'b1;
        pipe_csr_we = 1'b1; pipe_csr_i = 12'h123; pipe_wb_data = 32'h0BADC0DE;
        tick();
        #1;
        chk("post_reset_pass", {host_rsp_valid, csr_we, csr_stall, csr_i, csr_wdata}, {1'b0, 1'b1, 1'b0, 12'h123, 32'h0BADC0DE});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/csr_access_arbiter.md
Name: csr_access_arbiter

Overview:
- Shares the single CSR write port between the pipeline writeback stage and a host/debug request port.
- The pipeline has priority. A wait counter bounds host starvation; once it expires, the arbiter stalls the pipeline for one cycle and performs the host write.
- The block sits between stage-3 writeback and the CSR block, and drives the CSR block's stall, csr_i, csr_we and wb_data inputs.

Parameters:
- MAX_WAIT, 8: number of cycles a host request may be blocked before a forced grant; range 1..255.
- WAIT_W, 8: width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- pipe_stall  in  1  pipeline stall request.
- pipe_csr_i  in  12  pipeline CSR address.
- pipe_csr_we  in  1  pipeline CSR write enable.
- pipe_wb_data  in  32  pipeline write data.
- pipe_stall_out  out  1  freezes the pipeline while the host owns the port.
- host_valid  in  1  host write request valid.
- host_ready  out  1  host request accepted this cycle.
- host_addr  in  12  host CSR address.
- host_wdata  in  32  host write data.
- host_rsp_valid  out  1  response valid.
- host_rsp_ready  in  1  host accepts the response.
- host_rsp_data  out  32  CSR tohost value after the write.
- host_rsp_err  out  1  request rejected (see Optional Feature).
- csr_stall  out  1  to CSR stall.
- csr_i  out  12  to CSR address.
- csr_we  out  1  to CSR write enable.
- csr_wdata  out  32  to CSR wb_data.
- csrd_tohost  in  32  from CSR.

Behaviour:
- FSM states: IDLE, HOST_WR, HOST_RSP. Reset (asynchronous, active-low) forces:
  - state = IDLE, wait_cnt = 0;
  - host address/data latches = 0;
  - host_rsp_data = 0, host_rsp_err = 0;
  - this holds even mid-transaction; a request in flight is dropped with no response.
- Grant condition in IDLE:
  - grant = host_valid && (!pipe_csr_we || pipe_stall || wait_cnt == MAX_WAIT).
  - host_ready = (state == IDLE) && grant. host_ready is combinational.
- IDLE:
  - CSR outputs pass through the pipeline signals: csr_stall = pipe_stall, csr_i = pipe_csr_i, csr_we = pipe_csr_we, csr_wdata = pipe_wb_data.
  - pipe_stall_out = 0.
  - On host_valid && host_ready: latch host_addr/host_wdata, clear wait_cnt, go to HOST_WR.
  - If host_valid && !host_ready: wait_cnt increments, saturating at MAX_WAIT.
  - If !host_valid: wait_cnt = 0.
- HOST_WR (exactly 1 cycle):
  - CSR outputs: csr_stall = 0, csr_we = 1, csr_i and csr_wdata from the latches.
  - pipe_stall_out = 1. A pipeline write presented this cycle is not lost; the pipeline holds it under stall and re-presents it.
  - Next state: HOST_RSP.
- HOST_RSP:
  - On entry, host_rsp_data is registered from csrd_tohost (the CSR write has landed at the HOST_WR posedge).
  - host_rsp_valid = 1 while in this state.
  - CSR outputs return to pipeline pass-through; pipe_stall_out = 0.
  - On host_rsp_ready: go to IDLE. Otherwise hold host_rsp_data stable.
- Host requests are not accepted outside IDLE. At most one host transaction is outstanding.
- Simultaneous host_valid and pipe_csr_we with wait_cnt < MAX_WAIT: the pipeline wins and the host is blocked.
- pipe_stall = 1 in IDLE: the host is granted immediately, since the pipeline is not writing.
- Worst-case host latency from host_valid to host_ready is MAX_WAIT cycles. The pipeline loses at most 1 cycle per host transaction.

Optional Feature:
- Macro: CSR_ARB_ADDR_FILTER_EN.
- Defined:
  - A host request with host_addr != 12'h51E is still accepted.
  - HOST_WR is skipped: IDLE goes directly to HOST_RSP, with no CSR write and no pipe_stall_out.
  - host_rsp_err = 1 and host_rsp_data = current csrd_tohost.
  - A request to 12'h51E proceeds normally with host_rsp_err = 0.
- Not defined: all addresses are written and host_rsp_err is tied to 0.

Test Plan:
- Reset: hold reset low mid-HOST_RSP -> state IDLE, host_rsp_valid = 0, host_ready = 0, all registered outputs 0; after release, pass-through is active.
- Idle host write: pipe_csr_we = 0, host_valid with addr 0x51E, data 0xDEADBEEF -> host_ready in the same cycle. Next cycle: csr_we = 1, pipe_stall_out = 1. Following cycle: host_rsp_valid = 1, host_rsp_data = 0xDEADBEEF.
- Starvation: pipe_csr_we = 1 continuously, host_valid held, MAX_WAIT = 8 -> host_ready first asserts on the 9th cycle (wait_cnt == 8). The pipeline sees exactly 1 stall cycle, and its write of 0x11111111 lands afterwards.
- Pipeline stall grant: pipe_stall = 1, pipe_csr_we = 1, host_valid -> immediate grant. Then host_rsp_ready = 0 for 3 cycles -> host_rsp_data stable, host_ready = 0 throughout.
- Pass-through: 20 random pipeline writes with no host traffic -> csr_* equal pipe_* every cycle, and csrd_tohost tracks the last write to 0x51E.
- Filter (macro defined): host write to 0x300 -> no csr_we pulse, host_rsp_err = 1, host_rsp_data = prior tohost value.
